tcdm_bank_responder: RTL and testbench
======================================

// Module: tcdm_bank_responder
// PURPOSE
//  Slave-side endpoint of the TCDM/clos interconnect: accepts one request/cycle from an egress
//  node output (req/gnt), performs the access on a word-addressed register-file bank with byte
//  enables, and returns read data exactly MemLatency cycles after grant. The response carries no
//  tag and has no backpressure, so the interconnect's fixed-latency response mux stays in sync.
// PARAMETERS
//  NumWords     256  bank depth in words; power of two, >=2
//  DataWidth    32   word width; multiple of 8
//  MemLatency   1    grant-to-response latency in cycles; >=1
//  WriteRespOn  1    1: vld_o also pulses for writes; 0: reads only
// PORTS
//  clk_i    in   1                     clock
//  rst_i    in   1                     synchronous reset, active-high
//  req_i    in   1                     request valid
//  add_i    in   $clog2(NumWords)      word address
//  wen_i    in   1                     1: store, 0: load
//  be_i     in   DataWidth/8           byte enables (stores only)
//  wdata_i  in   DataWidth             store data
//  stall_i  in   1                     bank busy; blocks grant this cycle
//  gnt_o    out  1                     grant, combinational: req_i & ~stall_i & ~rst_i
//  vld_o    out  1                     response valid, MemLatency cycles after grant
//  rdata_o  out  DataWidth             load data, qualified by vld_o
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pipeline valid bits, vld_o and rdata_o -> 0. Bank contents NOT reset.
//    gnt_o forced 0 while rst_i=1. In-flight responses are dropped; no vld_o after reset releases.
//  - Handshake: transfer when req_i & gnt_o at a rising edge. Requester may drop req_i any cycle;
//    no ungranted state is kept (combinational grant, no queue).
//  - Store at grant edge: each byte b with be_i[b]=1 is written; others unchanged. be_i=0 is a
//    legal no-op store and still returns vld_o when WriteRespOn=1.
//  - Load at grant edge: word at add_i is read (one request/cycle, so no same-cycle RAW hazard),
//    into stage 0 of the latency pipe.
//  - Latency pipe: MemLatency stages of {valid,is_wr,data}; stage MemLatency-1 drives the outputs.
//    Grant at edge T -> vld_o high in cycle T+MemLatency (MemLatency=1: cycle after grant).
//    Back-to-back grants -> back-to-back vld_o; pipe always advances, never stalls.
//  - vld_o = valid_last & (~is_wr | WriteRespOn). rdata_o = load data when valid load, else '0
//    (stores and idle cycles drive 0; no hold of stale data).
//  - Load after store to same address in next cycle returns the new data (write visible at edge).
//  - stall_i=1 with req_i=1: gnt_o=0, no access, pipe inserts bubble; already-granted responses
//    still complete on schedule.
//  - Address: all add_i bits used; no out-of-range case.
//  - Assertions (translate_off): NumWords power of 2; DataWidth%8==0; MemLatency>=1;
//    no X on add_i/wen_i when req_i=1.
// STRUCTURE
//  - tcdm_pkg: typedef resp_stage_t {valid,is_wr,data} (parameterised via DataWidth in module
//    scope), localparam BeWidth=DataWidth/8 helper function.
//  - Sub-module tcdm_lat_pipe #(Depth=MemLatency, T) : shift register with sync active-high clear;
//    the bank array and byte-enable write logic stay in this module.
// TESTING
//  1 Reset: hold rst_i 3 cycles with req_i=1 -> gnt_o=0, vld_o=0, rdata_o=0 throughout.
//  2 Store 0xDEADBEEF be=4'hF @0x10, load @0x10 next cycle, MemLatency=1 -> vld_o on 2 consecutive
//    cycles (WriteRespOn=1); second returns rdata_o=0xDEADBEEF.
//  3 Partial store be=4'b0101 data 0x11223344 over 0xDEADBEEF @0x10 -> load returns 0xDE22BE44.
//  4 MemLatency=3, loads @0..7 every cycle -> vld_o high 8 cycles starting 3 after first grant, data in order.
//  5 stall_i=1 for 2 cycles during continuous req -> gnt_o=0 those cycles; exactly 2-cycle vld_o gap.
//  6 WriteRespOn=0, store then reset asserted 1 cycle after a load grant (MemLatency=2) -> no vld_o
//    for store, load response dropped, memory retains stored value on later load.

Source files
------------

// File: rtl/tcdm_pkg.sv
// Shared helpers for the TCDM bank responder.
// Holds width helpers and parameter sanity functions used by the responder
// and its latency pipe. The response stage struct depends on DataWidth, so it
// is declared inside the module that owns that parameter.
package tcdm_pkg;

    // Byte-enable width for a given data width.
    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/tcdm_lat_pipe.sv
// Fixed-depth shift register for in-flight responses.
// Ports:
//   clk_i  clock
//   clr_i  synchronous active-high clear of every stage
//   d_i    stage 0 input, captured every cycle (pipe never stalls)
//   q_o    last stage output
module tcdm_lat_pipe #(
    parameter int unsigned Depth = 1,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic clr_i,
    input  T     d_i,
    output T     q_o
);

    T stages_q [Depth];

    // Advance every cycle; clear drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            stages_q[0] <= d_i;
            for (int i = 1; i < int'(Depth); i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign q_o = stages_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_responder.sv
// Slave endpoint of the TCDM interconnect: one request per cycle against a
// word-addressed bank with byte enables, response exactly MemLatency cycles
// after grant, no tag and no backpressure.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_i          request valid
//   add_i          word address
//   wen_i          1 store, 0 load
//   be_i           byte enables for stores
//   wdata_i        store data
//   stall_i        bank busy, blocks the grant this cycle
//   gnt_o          combinational grant
//   vld_o          response valid
//   rdata_o        load data, zero unless a load response is valid
module tcdm_bank_responder
    import tcdm_pkg::*;
#(
    parameter int unsigned NumWords    = 256,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MemLatency  = 1,
    parameter bit          WriteRespOn = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic [$clog2(NumWords)-1:0] add_i,
    input  logic                        wen_i,
    input  logic [DataWidth/8-1:0]      be_i,
    input  logic [DataWidth-1:0]        wdata_i,
    input  logic                        stall_i,
    output logic                        gnt_o,
    output logic                        vld_o,
    output logic [DataWidth-1:0]        rdata_o
);

    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned BeWidth   = be_width(DataWidth);

    typedef struct packed {
        logic                 valid;
        logic                 is_wr;
        logic [DataWidth-1:0] data;
    } resp_stage_t;

    logic [DataWidth-1:0] bank_q [NumWords];
    logic                 gnt_c;
    resp_stage_t          stage_in_c;
    resp_stage_t          stage_out;

    // Grant is purely combinational so the requester never needs to hold state.
    assign gnt_c = req_i & ~stall_i & ~rst_i;
    assign gnt_o = gnt_c;

    // Byte-masked store; bank contents survive reset.
    always_ff @(posedge clk_i) begin
        if (gnt_c && wen_i) begin
            for (int b = 0; b < int'(BeWidth); b++) begin
                if (be_i[b]) begin
                    bank_q[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 payload: loads read the word as it stands before this edge.
    always_comb begin
        stage_in_c       = '0;
        stage_in_c.valid = gnt_c;
        stage_in_c.is_wr = gnt_c & wen_i;
        if (gnt_c && !wen_i) begin
            stage_in_c.data = bank_q[add_i];
        end
    end

    tcdm_lat_pipe #(
        .Depth (MemLatency),
        .T     (resp_stage_t)
    ) u_lat_pipe (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .d_i   (stage_in_c),
        .q_o   (stage_out)
    );

    // Store responses are optional; rdata only carries load data.
    assign vld_o   = stage_out.valid & (~stage_out.is_wr | WriteRespOn);
    assign rdata_o = (stage_out.valid && !stage_out.is_wr) ? stage_out.data : '0;

`ifndef SYNTHESIS
    logic unused_addr_width;
    assign unused_addr_width = ^AddrWidth;

    ap_params: assert property (@(posedge clk_i)
        is_pow2(NumWords) && (NumWords >= 2) && (DataWidth % 8 == 0) && (MemLatency >= 1));

    ap_no_x: assert property (@(posedge clk_i) disable iff (rst_i)
        req_i |-> !$isunknown({add_i, wen_i}));
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Three responders (latency 1/3/2, store responses on/on/off) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_tcdm_bank_responder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [7:0]  add_i = '0;
    logic        wen_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        stall_i = 1'b0;

    logic [2:0]  gnt_v;
    logic [2:0]  vld_v;
    logic [31:0] rd_v [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(1), .WriteRespOn(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i),
        .wdata_i(wdata_i), .stall_i(stall_i), .gnt_o(gnt_v[0]), .vld_o(vld_v[0]), .rdata_o(rd_v[0]));

    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(3), .WriteRespOn(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i),
        .wdata_i(wdata_i), .stall_i(stall_i), .gnt_o(gnt_v[1]), .vld_o(vld_v[1]), .rdata_o(rd_v[1]));

    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(2), .WriteRespOn(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i),
        .wdata_i(wdata_i), .stall_i(stall_i), .gnt_o(gnt_v[2]), .vld_o(vld_v[2]), .rdata_o(rd_v[2]));

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic bit wr_resp(input int k);
        return k != 2;
    endfunction

    // Behavioural model: memory image plus expected output per cycle index.
    localparam int NCyc = 4096;
    logic [31:0] mm [256];
    logic        ev [3][NCyc];
    logic [31:0] ed [3][NCyc];
    int          cyc = -1;
    bit          chk_en = 1'b0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NCyc; i++) begin
                ev[k][i] = 1'b0;
                ed[k][i] = '0;
            end
        end
    end

    always @(posedge clk) begin
        logic [31:0] rd;
        int          due;
        cyc++;
        if (rst_i) begin
            chk_en = 1'b1;
            for (int k = 0; k < 3; k++) begin
                for (int d = 0; d < 4; d++) begin
                    if (cyc + d < NCyc) begin
                        ev[k][cyc+d] = 1'b0;
                        ed[k][cyc+d] = '0;
                    end
                end
            end
        end else if (req_i && !stall_i) begin
            rd = mm[add_i];
            if (wen_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) mm[add_i][b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
            for (int k = 0; k < 3; k++) begin
                due = cyc + lat(k) - 1;
                if (due < NCyc) begin
                    ev[k][due] = wen_i ? wr_resp(k) : 1'b1;
                    ed[k][due] = wen_i ? 32'h0 : rd;
                end
            end
        end
    end

    // Per-cycle compare of all three responders against the model.
    always @(negedge clk) begin
        logic eg;
        if (chk_en && cyc >= 0 && cyc < NCyc) begin
            eg = req_i & ~stall_i & ~rst_i;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (gnt_v[k] !== eg) begin
                    bad++;
                    $display("FAIL gnt[%0d] cyc=%0d got=%b want=%b", k, cyc, gnt_v[k], eg);
                end
                total++;
                if (vld_v[k] !== ev[k][cyc]) begin
                    bad++;
                    $display("FAIL vld[%0d] cyc=%0d got=%b want=%b", k, cyc, vld_v[k], ev[k][cyc]);
                end
                total++;
                if (rd_v[k] !== ed[k][cyc]) begin
                    bad++;
                    $display("FAIL rdata[%0d] cyc=%0d got=%h want=%h", k, cyc, rd_v[k], ed[k][cyc]);
                end
            end
        end
    end

    // Watches responder C for any response during the store/reset window.
    bit mon_en = 1'b0;
    bit c_seen = 1'b0;
    always @(negedge clk) begin
        if (mon_en && vld_v[2]) c_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic [7:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input logic s, input logic rs);
        req_i = r; add_i = a; wen_i = w; be_i = b; wdata_i = d; stall_i = s; rst_i = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [7:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic s, input logic rs);
        set_in(r, a, w, b, d, s, rs);
        step();
    endtask

    task automatic idle();
        set_in(1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] got_q [$];
        int          first_j;
        logic [9:0]  vpat;
        logic [9:0]  gpat;

        // Reset held with a pending request: nothing granted, outputs quiet.
        set_in(1'b1, 8'h10, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
        repeat (3) begin
            step();
            @(negedge clk);
            chk("reset_gnt", 32'(gnt_v), 32'h0);
            chk("reset_vld", 32'(vld_v), 32'h0);
            chk("reset_rdata", rd_v[0] | rd_v[1] | rd_v[2], 32'h0);
        end

        // Give every word a known value.
        for (int i = 0; i < 256; i++) drive(1'b1, 8'(i), 1'b1, 4'hF, $urandom, 1'b0, 1'b0);
        idle();
        repeat (4) step();

        // Full store followed by a load of the same word.
        drive(1'b1, 8'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
        set_in(1'b1, 8'h10, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("st_resp_vld", 32'(vld_v[0]), 32'h1);
        chk("st_resp_rdata", rd_v[0], 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("ld_resp_vld", 32'(vld_v[0]), 32'h1);
        chk("ld_resp_rdata", rd_v[0], 32'hDEADBEEF);

        // Partial store merges with the existing word.
        drive(1'b1, 8'h10, 1'b1, 4'b0101, 32'h11223344, 1'b0, 1'b0);
        drive(1'b1, 8'h10, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("partial_rdata", rd_v[0], 32'hDE22BE44);
        repeat (4) step();

        // Latency-3 streaming loads of known words.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 1'b1, 4'hF, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        idle();
        repeat (4) step();
        first_j = -1;
        fork
            begin
                for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
                idle();
            end
            begin
                for (int j = 0; j < 14; j++) begin
                    @(negedge clk);
                    if (vld_v[1]) begin
                        if (first_j < 0) first_j = j;
                        got_q.push_back(rd_v[1]);
                    end
                end
            end
        join
        chk("lat3_first", 32'(first_j), 32'd3);
        chk("lat3_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("lat3_data", got_q[i], 32'hA000_0000 + 32'(i));
        repeat (3) step();

        // Two stalled cycles inside a continuous load stream.
        vpat = '0;
        gpat = '0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive(1'b1, 8'(i), 1'b0, 4'h0, 32'h0, (i == 3) || (i == 4), 1'b0);
                idle();
            end
            begin
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    vpat[j] = vld_v[0];
                    gpat[j] = gnt_v[0];
                end
            end
        join
        chk("stall_vld_pattern", 32'(vpat), 32'(10'b0111001110));
        chk("stall_gnt_pattern", 32'(gpat), 32'(10'b0011100111));
        repeat (3) step();

        // Store without response, then reset drops an in-flight load.
        c_seen = 1'b0;
        mon_en = 1'b1;
        drive(1'b1, 8'h20, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
        drive(1'b1, 8'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 8'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
        idle();
        repeat (3) step();
        mon_en = 1'b0;
        chk("no_c_resp", 32'(c_seen), 32'h0);
        drive(1'b1, 8'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("c_ld_early", 32'(vld_v[2]), 32'h0);
        @(negedge clk);
        chk("c_ld_vld", 32'(vld_v[2]), 32'h1);
        chk("c_ld_rdata", rd_v[2], 32'hCAFEF00D);
        repeat (3) step();

        // Randomized traffic with occasional stall and reset.
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 99) < 75, 8'($urandom), 1'($urandom), 4'($urandom), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end
        idle();
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
